alu_rf_sequencer: RTL and testbench
===================================

ALU_RF_SEQUENCER -- requirements
Module: alu_rf_sequencer

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  instruction offered.
- cmd_ready  out  1  sequencer can accept an instruction.
- instr  in  32  MIPS-format instruction word.
- read1  out  5  RF read port 1 address.
- read2  out  5  RF read port 2 address.
- write_reg  out  5  RF write address.
- reg_write  out  1  RF write enable.
- wb_data  out  32  RF write data.
- alu_op  out  2  ALU operation class.
- func_code  out  4  ALU function select.
- alu_out  in  32  ALU result.
- zero  in  1  ALU zero flag.
- done  out  1  one-cycle completion pulse.
- result  out  32  captured ALU result of the last instruction.
- branch_taken  out  1  last instruction was a taken BEQ.
- illegal  out  1  last instruction was unsupported.
- retired  out  16  count of completed instructions.

Function
REQ-002 SHALL use FSM states IDLE, DECODE, EXEC, WB, DONE.
REQ-003 SHALL drive cmd_ready=1 only in IDLE; a handshake is cmd_valid&cmd_ready on a rising edge.
REQ-004 On handshake SHALL latch instr into an internal register and go IDLE->DECODE; instr changes after the handshake SHALL have no effect.
REQ-005 DECODE SHALL drive read1=instr[25:21], read2=instr[20:16] (held through DECODE, EXEC and WB), classify the instruction, then go to EXEC.
REQ-006 Decode: opcode 000000 is R-type (alu_op=10); opcode 000100 is BEQ (alu_op=01, func_code=0110); every other opcode is illegal (alu_op=00, func_code=0010).
REQ-007 R-type funct SHALL map: 100000->0010 add, 100010->0110 sub, 100100->0000 and, 100101->0001 or, 101010->0111 slt; any other funct is illegal.
REQ-008 alu_op and func_code SHALL be valid throughout EXEC; at the end of EXEC, result<=alu_out and branch_taken<=(BEQ & zero).
REQ-009 EXEC->WB always; in WB, reg_write=1 for exactly one cycle only for a legal R-type with rd=instr[15:11]!=0; write_reg=rd; wb_data=result.
REQ-010 R-type with rd=0 SHALL complete normally with reg_write held 0.
REQ-011 WB->DONE; in DONE, done=1 for one cycle, illegal is updated, retired increments (16-bit wrap 0xFFFF->0x0000), then DONE->IDLE.
REQ-012 Latency: handshake at edge N -> done high during cycle N+4; next handshake possible at edge N+5 earliest.
REQ-013 Outside its active window, each RF/ALU control output SHALL be 0: reg_write=0 outside WB, and alu_op and func_code are 0 outside EXEC.
REQ-014 result, branch_taken and illegal SHALL hold their values until the next DONE; illegal instructions SHALL also update result.

Reset
REQ-015 rst SHALL win over every other input on the same edge; state->IDLE, and every output and register clears to 0, including retired and the latched instruction; cmd_ready=1 in the cycle after reset.
REQ-016 rst asserted in any state, including WB, SHALL suppress reg_write from the next cycle, produce no done pulse, and leave retired at 0.

Verification
REQ-017 add: instr=0x01095020 (rs=8, rt=9, rd=10), alu_out=0x00000007 -> read1=8, read2=9, func_code=0010 and alu_op=10 in EXEC, reg_write=1 in WB with write_reg=10 and wb_data=7, done at N+4, retired=1.
REQ-018 BEQ: instr=0x1109FFFF, zero=1 -> alu_op=01, func_code=0110, reg_write never 1, branch_taken=1; repeat with zero=0 -> branch_taken=0.
REQ-019 Illegal: opcode 0x23 -> illegal=1 at DONE, reg_write never 1; R-type funct 0x27 -> illegal=1.
REQ-020 Backpressure: cmd_valid held high with a changing instr during busy cycles -> cmd_ready=0 and nothing is accepted until IDLE; back-to-back completions are 5 cycles apart.
REQ-021 Reset mid-WB: rst=1 during WB -> reg_write=0 in the next cycle, no done pulse, retired=0, cmd_ready=1.
REQ-022 Wrap and rd=0: force retired to 0xFFFF via 65535 ops, then one more -> 0x0000; R-type with rd=0 -> done pulse with no write.

Source files
------------

// File: rtl/alu_rf_sequencer.sv
// alu_rf_sequencer: multi-cycle sequencer that takes one MIPS-format
// instruction at a time, drives register-file read/write addresses and
// ALU control, captures the ALU result and reports completion.
// Flow: IDLE -> DECODE -> EXEC -> WB -> DONE -> IDLE (5 cycles per op).
module alu_rf_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] instr,
   output logic [4:0]  read1,
   output logic [4:0]  read2,
   output logic [4:0]  write_reg,
   output logic        reg_write,
   output logic [31:0] wb_data,
   output logic [1:0]  alu_op,
   output logic [3:0]  func_code,
   input  logic [31:0] alu_out,
   input  logic        zero,
   output logic        done,
   output logic [31:0] result,
   output logic        branch_taken,
   output logic        illegal,
   output logic [15:0] retired
);

   typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, DONE} state_t;

   state_t      state, next_state;
   logic [31:0] instr_q;

   // combinational classification of the latched instruction
   logic [1:0]  cls_op;
   logic [3:0]  cls_func;
   logic        cls_beq;
   logic        cls_ill;
   logic        cls_wr;

   // classification captured at the end of DECODE
   logic [1:0]  dec_op;
   logic [3:0]  dec_func;
   logic        dec_beq;
   logic        dec_ill;
   logic        dec_wr;

   logic        handshake;
   assign handshake = cmd_valid && cmd_ready;

   // Instruction classifier; unknown opcodes and unknown R-type functs are illegal.
   always_comb begin
      cls_op   = 2'b00;
      cls_func = 4'b0010;
      cls_beq  = 1'b0;
      cls_ill  = 1'b1;
      case (instr_q[31:26])
         6'b000000: begin
            cls_op = 2'b10;
            case (instr_q[5:0])
               6'b100000: begin cls_func = 4'b0010; cls_ill = 1'b0; end
               6'b100010: begin cls_func = 4'b0110; cls_ill = 1'b0; end
               6'b100100: begin cls_func = 4'b0000; cls_ill = 1'b0; end
               6'b100101: begin cls_func = 4'b0001; cls_ill = 1'b0; end
               6'b101010: begin cls_func = 4'b0111; cls_ill = 1'b0; end
               default:   cls_ill = 1'b1;
            endcase
         end
         6'b000100: begin
            cls_op   = 2'b01;
            cls_func = 4'b0110;
            cls_beq  = 1'b1;
            cls_ill  = 1'b0;
         end
         default: cls_ill = 1'b1;
      endcase
      // only a legal R-type with a non-zero destination writes the RF
      cls_wr = (instr_q[31:26] == 6'b000000) && !cls_ill && (instr_q[15:11] != 5'd0);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Instruction latch, decode capture, result/flag capture and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q      <= 32'd0;
         dec_op       <= 2'b00;
         dec_func     <= 4'd0;
         dec_beq      <= 1'b0;
         dec_ill      <= 1'b0;
         dec_wr       <= 1'b0;
         result       <= 32'd0;
         branch_taken <= 1'b0;
         illegal      <= 1'b0;
         retired      <= 16'd0;
      end else begin
         if (state == IDLE && handshake) instr_q <= instr;
         if (state == DECODE) begin
            dec_op   <= cls_op;
            dec_func <= cls_func;
            dec_beq  <= cls_beq;
            dec_ill  <= cls_ill;
            dec_wr   <= cls_wr;
         end
         if (state == EXEC) begin
            result       <= alu_out;
            branch_taken <= dec_beq && zero;
         end
         // status becomes visible together with the done pulse
         if (state == WB) begin
            illegal <= dec_ill;
            retired <= retired + 16'd1;
         end
      end
   end

   // Next-state and Moore outputs; every control is 0 outside its window.
   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      read1      = 5'd0;
      read2      = 5'd0;
      write_reg  = 5'd0;
      reg_write  = 1'b0;
      wb_data    = 32'd0;
      alu_op     = 2'b00;
      func_code  = 4'd0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) next_state = DECODE;
         end
         DECODE: begin
            read1      = instr_q[25:21];
            read2      = instr_q[20:16];
            next_state = EXEC;
         end
         EXEC: begin
            read1      = instr_q[25:21];
            read2      = instr_q[20:16];
            alu_op     = dec_op;
            func_code  = dec_func;
            next_state = WB;
         end
         WB: begin
            read1      = instr_q[25:21];
            read2      = instr_q[20:16];
            write_reg  = instr_q[15:11];
            reg_write  = dec_wr;
            wb_data    = result;
            next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Directed bench for alu_rf_sequencer: a table of single instructions with
// hand-computed expectations, plus sequences for reset, backpressure,
// reset during write-back and retire-counter wrap.
module tb_alu_rf_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] instr;
   logic [4:0]  read1, read2, write_reg;
   logic        reg_write;
   logic [31:0] wb_data;
   logic [1:0]  alu_op;
   logic [3:0]  func_code;
   logic [31:0] alu_out;
   logic        zero;
   logic        done;
   logic [31:0] result;
   logic        branch_taken;
   logic        illegal;
   logic [15:0] retired;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          t1, t2;
   logic [15:0] exp_ret;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_rf_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .instr(instr), .read1(read1), .read2(read2), .write_reg(write_reg),
      .reg_write(reg_write), .wb_data(wb_data), .alu_op(alu_op),
      .func_code(func_code), .alu_out(alu_out), .zero(zero), .done(done),
      .result(result), .branch_taken(branch_taken), .illegal(illegal),
      .retired(retired)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] aout;
      logic        z;
      logic        ctl;   // compare alu_op/func_code in EXEC
      logic [1:0]  op;
      logic [3:0]  fn;
      logic        rw;
      logic [4:0]  wr;
      logic        br;
      logic        ill;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // One instruction from an IDLE cycle through DONE, checked every cycle.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_done", {31'd0, done}, 32'd0);
      cmd_valid = 1'b1; instr = v.instr; alu_out = v.aout; zero = v.z;
      @(negedge clk);  // DECODE
      cmd_valid = 1'b0; instr = 32'hFFFF_FFFF;
      chk("dec_read1", {27'd0, read1}, {27'd0, v.instr[25:21]});
      chk("dec_read2", {27'd0, read2}, {27'd0, v.instr[20:16]});
      chk("dec_alu_op", {30'd0, alu_op}, 32'd0);
      chk("dec_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);  // EXEC
      chk("exec_read1", {27'd0, read1}, {27'd0, v.instr[25:21]});
      chk("exec_reg_write", {31'd0, reg_write}, 32'd0);
      if (v.ctl) begin
         chk("exec_alu_op", {30'd0, alu_op}, {30'd0, v.op});
         chk("exec_func", {28'd0, func_code}, {28'd0, v.fn});
      end
      @(negedge clk);  // WB
      chk("wb_alu_op", {30'd0, alu_op}, 32'd0);
      chk("wb_func", {28'd0, func_code}, 32'd0);
      chk("wb_reg_write", {31'd0, reg_write}, {31'd0, v.rw});
      chk("wb_read2", {27'd0, read2}, {27'd0, v.instr[20:16]});
      if (v.rw) begin
         chk("wb_write_reg", {27'd0, write_reg}, {27'd0, v.wr});
         chk("wb_data", wb_data, v.aout);
      end
      chk("wb_done", {31'd0, done}, 32'd0);
      @(negedge clk);  // DONE
      exp_ret = exp_ret + 16'd1;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_reg_write", {31'd0, reg_write}, 32'd0);
      chk("done_illegal", {31'd0, illegal}, {31'd0, v.ill});
      chk("done_branch", {31'd0, branch_taken}, {31'd0, v.br});
      chk("done_result", result, v.aout);
      chk("done_retired", {16'd0, retired}, {16'd0, exp_ret});
   endtask

   initial begin
      //          instr          aout           z     ctl   op     fn       rw    wr     br    ill
      vecs[0] = '{32'h0109_5020, 32'h0000_0007, 1'b0, 1'b1, 2'b10, 4'b0010, 1'b1, 5'd10, 1'b0, 1'b0}; // add
      vecs[1] = '{32'h0022_1822, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 4'b0110, 1'b1, 5'd3,  1'b0, 1'b0}; // sub
      vecs[2] = '{32'h0085_3024, 32'h0000_000F, 1'b0, 1'b1, 2'b10, 4'b0000, 1'b1, 5'd6,  1'b0, 1'b0}; // and
      vecs[3] = '{32'h03FE_E825, 32'hA5A5_0000, 1'b0, 1'b1, 2'b10, 4'b0001, 1'b1, 5'd29, 1'b0, 1'b0}; // or
      vecs[4] = '{32'h00E8_482A, 32'h0000_0001, 1'b0, 1'b1, 2'b10, 4'b0111, 1'b1, 5'd9,  1'b0, 1'b0}; // slt
      vecs[5] = '{32'h1109_FFFF, 32'h0000_0000, 1'b1, 1'b1, 2'b01, 4'b0110, 1'b0, 5'd0,  1'b1, 1'b0}; // beq taken
      vecs[6] = '{32'h1109_FFFF, 32'h0000_0005, 1'b0, 1'b1, 2'b01, 4'b0110, 1'b0, 5'd0,  1'b0, 1'b0}; // beq not taken
      vecs[7] = '{32'h8D09_0004, 32'h0000_1234, 1'b1, 1'b1, 2'b00, 4'b0010, 1'b0, 5'd0,  1'b0, 1'b1}; // lw: illegal
      vecs[8] = '{32'h0022_1827, 32'h0000_4321, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 5'd0,  1'b0, 1'b1}; // nor: illegal
      vecs[9] = '{32'h0109_0020, 32'h0000_0055, 1'b0, 1'b1, 2'b10, 4'b0010, 1'b0, 5'd0,  1'b0, 1'b0}; // add rd=0

      // reset with a valid command offered: reset must win
      rst = 1'b1; cmd_valid = 1'b1; instr = 32'h0109_5020; alu_out = 32'h0; zero = 1'b0;
      exp_ret = 16'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0; cmd_valid = 1'b0;
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, illegal, branch_taken, done}, 32'd0);
      chk("rst_ctl", {20'd0, reg_write, alu_op, func_code, read1}, 32'd0);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // backpressure: valid held, instr churning while busy
      @(negedge clk);
      chk("bp_ready0", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; instr = 32'h0109_5020; alu_out = 32'h0000_0003; zero = 1'b0;
      t1 = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         instr = $urandom;
         chk("bp_busy_ready", {31'd0, cmd_ready}, 32'd0);
         if (i == 3) chk("bp_wr_a", {27'd0, write_reg}, 32'd10);
         if (i == 4) begin chk("bp_done_a", {31'd0, done}, 32'd1); t1 = cyc; end
      end
      exp_ret = exp_ret + 16'd1;
      @(negedge clk);
      chk("bp_ready1", {31'd0, cmd_ready}, 32'd1);
      instr = 32'h0109_2820;  // add rd=5, accepted at the next edge
      @(negedge clk);
      cmd_valid = 1'b0;
      t2 = 0;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         if (i == 3) chk("bp_wr_b", {27'd0, write_reg}, 32'd5);
         if (i == 4) begin chk("bp_done_b", {31'd0, done}, 32'd1); t2 = cyc; end
      end
      exp_ret = exp_ret + 16'd1;
      chk("bp_spacing", t2 - t1, 32'd5);
      chk("bp_retired", {16'd0, retired}, {16'd0, exp_ret});

      // reset during write-back
      @(negedge clk);
      cmd_valid = 1'b1; instr = 32'h0109_5020; alu_out = 32'h0000_0009;
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rwb_reg_write_pre", {31'd0, reg_write}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_ret = 16'd0;
      chk("rwb_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rwb_done", {31'd0, done}, 32'd0);
      chk("rwb_retired", {16'd0, retired}, 32'd0);
      chk("rwb_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rwb_result", result, 32'd0);
      @(negedge clk);
      chk("rwb_no_done", {31'd0, done}, 32'd0);

      // retire counter wrap: preload 0xFFFF, then one more instruction
      force dut.retired = 16'hFFFF;
      #1 release dut.retired;
      exp_ret = 16'hFFFF;
      chk("wrap_preload", {16'd0, retired}, 32'h0000_FFFF);
      run_vec(vecs[0]);
      chk("wrap_zero", {16'd0, retired}, 32'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
